// File: rtl/cache_ctrl_pkg.sv
// Shared encodings for the key/value cache operation controller.
package cache_ctrl_pkg;

    typedef enum logic [1:0] {
        OP_GET  = 2'd0,
        OP_PUT  = 2'd1,
        OP_DEL  = 2'd2,
        OP_RSVD = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_OK        = 2'd0,
        ST_NOT_FOUND = 2'd1,
        ST_FULL      = 2'd2,
        ST_BAD_REQ   = 2'd3
    } status_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_WRITE  = 3'd2,
        S_DELETE = 3'd3,
        S_RESP   = 3'd4
    } state_e;

endpackage

// File: rtl/cache_op_controller_if.sv
// Request/response handshake bundle between a requester (master) and the controller (slave).
interface cache_op_if #(
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64
);
    logic                   req_valid;
    logic                   req_ready;
    logic [1:0]             req_op;
    logic [KEY_WIDTH-1:0]   req_key;
    logic [VALUE_WIDTH-1:0] req_value;
    logic                   resp_valid;
    logic                   resp_ready;
    logic [1:0]             resp_status;
    logic [VALUE_WIDTH-1:0] resp_value;

    modport master (
        output req_valid, req_op, req_key, req_value, resp_ready,
        input  req_ready, resp_valid, resp_status, resp_value
    );

    modport slave (
        input  req_valid, req_op, req_key, req_value, resp_ready,
        output req_ready, resp_valid, resp_status, resp_value
    );
endinterface

// File: rtl/free_slot_finder.sv
// Combinational priority pick of the lowest-index unused slot, as a one-hot vector.
module free_slot_finder #(
    parameter int NUM_ENTRIES = 16
) (
    input  logic [NUM_ENTRIES-1:0] used_mirror,
    output logic [NUM_ENTRIES-1:0] free_idx,
    output logic                   any_free
);
    logic [NUM_ENTRIES-1:0] free_vec;
    logic [NUM_ENTRIES:0]   seen_free;

    assign free_vec     = ~used_mirror;
    assign seen_free[0] = 1'b0;

    // seen_free[i] is set once any lower slot is free, masking all higher ones.
    for (genvar gi = 0; gi < NUM_ENTRIES; gi++) begin : g_pick
        assign free_idx[gi]      = free_vec[gi] & ~seen_free[gi];
        assign seen_free[gi + 1] = seen_free[gi] | free_vec[gi];
    end

    assign any_free = seen_free[NUM_ENTRIES];
endmodule

// File: rtl/cache_op_controller.sv
// Sequences GET/PUT/DEL requests against a combinational-read key/value memory block
// and keeps a mirror of slot occupancy for free-slot allocation.
module cache_op_controller
    import cache_ctrl_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    parameter int KEY_WIDTH   = 16,
    parameter int VALUE_WIDTH = 64,
    parameter int CNT_W       = $clog2(NUM_ENTRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    cache_op_if.slave              req_if,
    output logic [CNT_W-1:0]       count_out,
    output logic                   mem_write,
    output logic                   mem_select_by_index,
    output logic                   mem_delete,
    output logic [KEY_WIDTH-1:0]   mem_key,
    output logic [VALUE_WIDTH-1:0] mem_value,
    output logic [NUM_ENTRIES-1:0] mem_index,
    input  logic [VALUE_WIDTH-1:0] mem_value_in,
    input  logic [NUM_ENTRIES-1:0] mem_index_in,
    input  logic                   mem_hit
);
    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [VALUE_WIDTH-1:0] value_q, value_d;
    logic [NUM_ENTRIES-1:0] used_q, used_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   req_ready_q, req_ready_d;
    logic                   resp_valid_q, resp_valid_d;
    status_e                resp_status_q, resp_status_d;
    logic [VALUE_WIDTH-1:0] resp_value_q, resp_value_d;
    logic                   mem_write_q, mem_write_d;
    logic                   mem_delete_q, mem_delete_d;
    logic [NUM_ENTRIES-1:0] mem_index_q, mem_index_d;
    logic [NUM_ENTRIES-1:0] free_idx;
    logic                   any_free;

    free_slot_finder #(.NUM_ENTRIES(NUM_ENTRIES)) u_free (
        .used_mirror (used_q),
        .free_idx    (free_idx),
        .any_free    (any_free)
    );

    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        key_d         = key_q;
        value_d       = value_q;
        used_d        = used_q;
        count_d       = count_q;
        req_ready_d   = req_ready_q;
        resp_valid_d  = resp_valid_q;
        resp_status_d = resp_status_q;
        resp_value_d  = resp_value_q;
        mem_write_d   = 1'b0;
        mem_delete_d  = 1'b0;
        mem_index_d   = '0;

        case (state_q)
            S_IDLE: begin
                if (req_if.req_valid) begin
                    op_d        = op_e'(req_if.req_op);
                    key_d       = req_if.req_key;
                    value_d     = req_if.req_value;
                    req_ready_d = 1'b0;
                    if (op_e'(req_if.req_op) == OP_RSVD || req_if.req_key == '0) begin
                        state_d       = S_RESP;
                        resp_valid_d  = 1'b1;
                        resp_status_d = ST_BAD_REQ;
                        resp_value_d  = '0;
                    end else begin
                        state_d = S_LOOKUP;
                    end
                end
            end
            S_LOOKUP: begin
                // The memory answers combinationally to mem_key, so hit/index/value are valid now.
                state_d       = S_RESP;
                resp_valid_d  = 1'b1;
                resp_value_d  = '0;
                resp_status_d = ST_NOT_FOUND;
                case (op_q)
                    OP_GET: begin
                        if (mem_hit) begin
                            resp_status_d = ST_OK;
                            resp_value_d  = mem_value_in;
                        end
                    end
                    OP_PUT: begin
                        if (mem_hit || any_free) begin
                            state_d      = S_WRITE;
                            resp_valid_d = 1'b0;
                            mem_write_d  = 1'b1;
                            mem_index_d  = mem_hit ? mem_index_in : free_idx;
                        end else begin
                            resp_status_d = ST_FULL;
                        end
                    end
                    OP_DEL: begin
                        if (mem_hit) begin
                            state_d      = S_DELETE;
                            resp_valid_d = 1'b0;
                            mem_delete_d = 1'b1;
                            mem_index_d  = mem_index_in;
                        end
                    end
                    default: resp_status_d = ST_BAD_REQ;
                endcase
            end
            S_WRITE: begin
                used_d = used_q | mem_index_q;
                if ((used_q & mem_index_q) == '0) begin
                    count_d = count_q + CNT_W'(1);
                end
                state_d       = S_RESP;
                resp_valid_d  = 1'b1;
                resp_status_d = ST_OK;
                resp_value_d  = '0;
            end
            S_DELETE: begin
                used_d = used_q & ~mem_index_q;
                if ((used_q & mem_index_q) != '0) begin
                    count_d = count_q - CNT_W'(1);
                end
                state_d       = S_RESP;
                resp_valid_d  = 1'b1;
                resp_status_d = ST_OK;
                resp_value_d  = '0;
            end
            S_RESP: begin
                if (req_if.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b0;
                req_ready_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            op_q          <= OP_GET;
            key_q         <= '0;
            value_q       <= '0;
            used_q        <= '0;
            count_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_status_q <= ST_OK;
            resp_value_q  <= '0;
            mem_write_q   <= 1'b0;
            mem_delete_q  <= 1'b0;
            mem_index_q   <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            key_q         <= key_d;
            value_q       <= value_d;
            used_q        <= used_d;
            count_q       <= count_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_status_q <= resp_status_d;
            resp_value_q  <= resp_value_d;
            mem_write_q   <= mem_write_d;
            mem_delete_q  <= mem_delete_d;
            mem_index_q   <= mem_index_d;
        end
    end

    assign req_if.req_ready   = req_ready_q;
    assign req_if.resp_valid  = resp_valid_q;
    assign req_if.resp_status = resp_status_q;
    assign req_if.resp_value  = resp_value_q;

    assign count_out           = count_q;
    assign mem_write           = mem_write_q;
    assign mem_delete          = mem_delete_q;
    assign mem_index           = mem_index_q;
    assign mem_select_by_index = 1'b0;
    assign mem_key             = key_q;
    assign mem_value           = value_q;
endmodule

// File: tb/tb_cache_op_controller.sv
// Directed table-driven bench for cache_op_controller with a small behavioural memory block.
module tb_cache_op_controller;
    import cache_ctrl_pkg::*;

    localparam int NE = 4;
    localparam int KW = 16;
    localparam int VW = 64;
    localparam int CW = $clog2(NE + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [CW-1:0] count_out;
    logic          mem_write, mem_select_by_index, mem_delete, mem_hit;
    logic [KW-1:0] mem_key;
    logic [VW-1:0] mem_value, mem_value_in;
    logic [NE-1:0] mem_index, mem_index_in;

    cache_op_if #(.KEY_WIDTH(KW), .VALUE_WIDTH(VW)) bus ();

    cache_op_controller #(.NUM_ENTRIES(NE), .KEY_WIDTH(KW), .VALUE_WIDTH(VW)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req_if              (bus),
        .count_out           (count_out),
        .mem_write           (mem_write),
        .mem_select_by_index (mem_select_by_index),
        .mem_delete          (mem_delete),
        .mem_key             (mem_key),
        .mem_value           (mem_value),
        .mem_index           (mem_index),
        .mem_value_in        (mem_value_in),
        .mem_index_in        (mem_index_in),
        .mem_hit             (mem_hit)
    );

    always #5 clk = ~clk;

    // Behavioural memory block: combinational lookup, writes/deletes at the clock edge.
    logic [KW-1:0] m_key [NE];
    logic [VW-1:0] m_val [NE];
    logic [NE-1:0] m_vld;

    always @(posedge clk) begin
        if (rst) begin
            m_vld <= '0;
        end else begin
            for (int i = 0; i < NE; i++) begin
                if (mem_write && mem_index[i]) begin
                    m_vld[i] <= 1'b1;
                    m_key[i] <= mem_key;
                    m_val[i] <= mem_value;
                end else if (mem_delete && mem_index[i]) begin
                    m_vld[i] <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        mem_hit      = 1'b0;
        mem_index_in = '0;
        mem_value_in = '0;
        for (int i = 0; i < NE; i++) begin
            if (m_vld[i] === 1'b1 && m_key[i] == mem_key) begin
                mem_hit         = 1'b1;
                mem_index_in[i] = 1'b1;
                mem_value_in    = m_val[i];
            end
        end
    end

    typedef struct {
        logic [1:0]    op;
        logic [KW-1:0] key;
        logic [VW-1:0] value;
        logic [1:0]    st;
        logic [VW-1:0] rv;
        int            lat;
        int            nwr;
        int            ndel;
        logic [NE-1:0] idx;
        int            cnt;
    } vec_t;

    vec_t vecs [21];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_req(input vec_t v, input int n);
        int            cyc;
        int            nwr;
        int            ndel;
        int            stray;
        logic [NE-1:0] idx;
        logic          got;
        nwr = 0; ndel = 0; stray = 0; idx = '0; got = 1'b0; cyc = 0;
        chk("req_ready_idle", {63'd0, bus.req_ready}, 64'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = v.op;
        bus.req_key   = v.key;
        bus.req_value = v.value;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("req_ready_busy", {63'd0, bus.req_ready}, 64'd0);
        for (int c = 1; c <= 10; c++) begin
            cyc = c;
            if (mem_write)  begin nwr++;  idx = mem_index; end
            if (mem_delete) begin ndel++; idx = mem_index; end
            if (!mem_write && !mem_delete && mem_index != '0) stray++;
            if (bus.resp_valid) begin got = 1'b1; break; end
            @(posedge clk); #1;
        end
        chk("resp_timeout", {63'd0, got}, 64'd1);
        chk("latency", 64'(cyc), 64'(v.lat));
        chk("status", {62'd0, bus.resp_status}, {62'd0, v.st});
        chk("resp_value", bus.resp_value, v.rv);
        chk("write_pulses", 64'(nwr), 64'(v.nwr));
        chk("delete_pulses", 64'(ndel), 64'(v.ndel));
        chk("strobe_index", {60'd0, idx}, {60'd0, v.idx});
        chk("stray_index", 64'(stray), 64'd0);
        chk("count_out", 64'(count_out), 64'(v.cnt));
        $display("txn %0d op=%0d key=%h status=%0d value=%h lat=%0d idx=%b count=%0d",
                 n, v.op, v.key, bus.resp_status, bus.resp_value, cyc, idx, count_out);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("resp_valid_drop", {63'd0, bus.resp_valid}, 64'd0);
    endtask

    initial begin
        //               op      key       value               status        rv                lat wr del idx   cnt
        vecs[0]  = '{OP_PUT,  16'h0012, 64'hDEAD_BEEF, ST_OK,        64'h0,         3, 1, 0, 4'h1, 1};
        vecs[1]  = '{OP_GET,  16'h0012, 64'h0,         ST_OK,        64'hDEAD_BEEF, 2, 0, 0, 4'h0, 1};
        vecs[2]  = '{OP_PUT,  16'h0012, 64'h1,         ST_OK,        64'h0,         3, 1, 0, 4'h1, 1};
        vecs[3]  = '{OP_GET,  16'h0012, 64'h0,         ST_OK,        64'h1,         2, 0, 0, 4'h0, 1};
        vecs[4]  = '{OP_PUT,  16'h0022, 64'h2,         ST_OK,        64'h0,         3, 1, 0, 4'h2, 2};
        vecs[5]  = '{OP_PUT,  16'h0033, 64'h3,         ST_OK,        64'h0,         3, 1, 0, 4'h4, 3};
        vecs[6]  = '{OP_PUT,  16'h0044, 64'h4,         ST_OK,        64'h0,         3, 1, 0, 4'h8, 4};
        vecs[7]  = '{OP_PUT,  16'h0055, 64'h5,         ST_FULL,      64'h0,         2, 0, 0, 4'h0, 4};
        vecs[8]  = '{OP_DEL,  16'h0022, 64'h0,         ST_OK,        64'h0,         3, 0, 1, 4'h2, 3};
        vecs[9]  = '{OP_DEL,  16'h0022, 64'h0,         ST_NOT_FOUND, 64'h0,         2, 0, 0, 4'h0, 3};
        vecs[10] = '{OP_GET,  16'h0022, 64'h0,         ST_NOT_FOUND, 64'h0,         2, 0, 0, 4'h0, 3};
        vecs[11] = '{OP_PUT,  16'h0066, 64'h6,         ST_OK,        64'h0,         3, 1, 0, 4'h2, 4};
        vecs[12] = '{OP_GET,  16'h0066, 64'h0,         ST_OK,        64'h6,         2, 0, 0, 4'h0, 4};
        vecs[13] = '{OP_GET,  16'h0000, 64'h0,         ST_BAD_REQ,   64'h0,         1, 0, 0, 4'h0, 4};
        vecs[14] = '{OP_RSVD, 16'h0012, 64'h0,         ST_BAD_REQ,   64'h0,         1, 0, 0, 4'h0, 4};
        vecs[15] = '{OP_PUT,  16'h0000, 64'h9,         ST_BAD_REQ,   64'h0,         1, 0, 0, 4'h0, 4};
        vecs[16] = '{OP_DEL,  16'h0012, 64'h0,         ST_OK,        64'h0,         3, 0, 1, 4'h1, 3};
        vecs[17] = '{OP_PUT,  16'h0077, 64'h7,         ST_OK,        64'h0,         3, 1, 0, 4'h1, 4};
        vecs[18] = '{OP_DEL,  16'h0033, 64'h0,         ST_OK,        64'h0,         3, 0, 1, 4'h4, 3};
        // After a mid-operation reset the memory and mirror are empty again.
        vecs[19] = '{OP_GET,  16'h0012, 64'h0,         ST_NOT_FOUND, 64'h0,         2, 0, 0, 4'h0, 0};
        vecs[20] = '{OP_PUT,  16'h0012, 64'hA,         ST_OK,        64'h0,         3, 1, 0, 4'h1, 1};

        bus.req_valid  = 1'b0;
        bus.req_op     = 2'd0;
        bus.req_key    = '0;
        bus.req_value  = '0;
        bus.resp_ready = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rst_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rst_resp_status", {62'd0, bus.resp_status}, 64'd0);
        chk("rst_resp_value", bus.resp_value, 64'd0);
        chk("rst_count", 64'(count_out), 64'd0);
        chk("rst_mem_strobes", {61'd0, mem_write, mem_delete, mem_select_by_index}, 64'd0);
        chk("rst_mem_index", {60'd0, mem_index}, 64'd0);
        chk("rst_mem_key", {48'd0, mem_key}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i <= 18; i++) do_req(vecs[i], i);

        // Response back-pressure: GET 0x77 held in RESP for 5 cycles.
        begin
            logic got;
            got = 1'b0;
            bus.req_valid = 1'b1;
            bus.req_op    = OP_GET;
            bus.req_key   = 16'h0077;
            bus.req_value = '0;
            @(posedge clk); #1;
            bus.req_valid = 1'b0;
            for (int c = 0; c < 10; c++) begin
                if (bus.resp_valid) begin got = 1'b1; break; end
                @(posedge clk); #1;
            end
            chk("hold_timeout", {63'd0, got}, 64'd1);
            for (int c = 0; c < 5; c++) begin
                @(posedge clk); #1;
                chk("hold_resp_valid", {63'd0, bus.resp_valid}, 64'd1);
                chk("hold_status", {62'd0, bus.resp_status}, {62'd0, ST_OK});
                chk("hold_value", bus.resp_value, 64'h7);
                chk("hold_req_ready", {63'd0, bus.req_ready}, 64'd0);
            end
            $display("txn hold op=0 key=0077 status=%0d value=%h", bus.resp_status, bus.resp_value);
            bus.resp_ready = 1'b1;
            @(posedge clk); #1;
            bus.resp_ready = 1'b0;
            chk("hold_release", {63'd0, bus.req_ready}, 64'd1);
        end

        // Reset during LOOKUP of a PUT that would otherwise write the free slot 0x4.
        bus.req_valid = 1'b1;
        bus.req_op    = OP_PUT;
        bus.req_key   = 16'h0099;
        bus.req_value = 64'h99;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_mem_write", {63'd0, mem_write}, 64'd0);
        chk("rstmid_mem_index", {60'd0, mem_index}, 64'd0);
        chk("rstmid_req_ready", {63'd0, bus.req_ready}, 64'd1);
        chk("rstmid_resp_valid", {63'd0, bus.resp_valid}, 64'd0);
        chk("rstmid_count", 64'(count_out), 64'd0);
        $display("txn rst_mid op=1 key=0099 count=%0d req_ready=%0d", count_out, bus.req_ready);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstmid_no_write_after", {63'd0, mem_write}, 64'd0);

        for (int i = 19; i <= 20; i++) do_req(vecs[i], i);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
